load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 78 +++++++
 tb/tb_load_store_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: CPU-side request/response handshake of the load/store unit.
interface load_store_unit_if #(
    parameter int BASE_BIT_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) ();
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_we;
    logic [1:0]                  req_dlen;
    logic                        req_signed;
    logic [ADDR_WIDTH-1:0]       req_addr;
    logic [4*BASE_BIT_WIDTH-1:0] req_wdata;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [4*BASE_BIT_WIDTH-1:0] resp_rdata;
    logic                        resp_fault;

    modport master (
        output req_valid, req_we, req_dlen, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_dlen, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding CPU load/store bridge to a byte-addressed memory
// with size-based extension and top-of-address-space fault detection.
module load_store_unit #(
    parameter int BASE_BIT_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    load_store_unit_if.slave            cpu,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [4*BASE_BIT_WIDTH-1:0] mem_data,
    output logic                        mem_we,
    output logic [1:0]                  mem_dlen,
    input  logic [4*BASE_BIT_WIDTH-1:0] mem_q
);
    localparam int BW = BASE_BIT_WIDTH;
    localparam int W = 4 * BW;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state, nxt;
    logic                  we_q, sgn_q, fault_q, resp_fault_q;
    logic [1:0]            dlen_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [W-1:0]          wdata_q, rdata_q, ext;
    logic                  fault;

    // one extra bit so an access running past the top address is caught, never wrapped
    assign fault = ({1'b0, cpu.req_addr} + {{(ADDR_WIDTH-1){1'b0}}, cpu.req_dlen})
                   > {1'b0, {ADDR_WIDTH{1'b1}}};

    always_comb begin
        nxt = state == IDLE   ? (cpu.req_valid ? ACCESS : IDLE) :
              state == ACCESS ? RESP :
              (cpu.resp_ready ? IDLE : RESP);
        ext = dlen_q == 2'd0 ? {{(3*BW){sgn_q & mem_q[BW-1]}},   mem_q[BW-1:0]}   :
              dlen_q == 2'd1 ? {{(2*BW){sgn_q & mem_q[2*BW-1]}}, mem_q[2*BW-1:0]} :
              dlen_q == 2'd2 ? {{BW{sgn_q & mem_q[3*BW-1]}},     mem_q[3*BW-1:0]} :
              mem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            sgn_q        <= 1'b0;
            fault_q      <= 1'b0;
            dlen_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && cpu.req_valid) begin
                we_q    <= cpu.req_we;
                sgn_q   <= cpu.req_signed;
                fault_q <= fault;
                dlen_q  <= cpu.req_dlen;
                addr_q  <= cpu.req_addr;
                wdata_q <= cpu.req_wdata;
            end
            if (state == ACCESS) begin
                rdata_q      <= (we_q | fault_q) ? '0 : ext;
                resp_fault_q <= fault_q;
            end
        end
    end

    assign cpu.req_ready  = state == IDLE;
    assign cpu.resp_valid = state == RESP;
    assign cpu.resp_rdata = rdata_q;
    assign cpu.resp_fault = resp_fault_q;
    assign mem_addr       = addr_q;
    assign mem_data       = wdata_q;
    assign mem_dlen       = dlen_q;
    assign mem_we         = state == ACCESS && we_q && !fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit against a
// behavioural byte memory.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mem_addr;
    logic [31:0] mem_data, mem_q;
    logic        mem_we;
    logic [1:0]  mem_dlen;
    logic [7:0]  mem [0:4095];
    int          checks = 0, failures = 0, we_cnt = 0, cyc = 0;

    always #5 clk = ~clk;

    load_store_unit_if #(.BASE_BIT_WIDTH(8), .ADDR_WIDTH(12)) cpu ();

    load_store_unit #(.BASE_BIT_WIDTH(8), .ADDR_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .cpu(cpu),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_dlen(mem_dlen), .mem_q(mem_q)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            for (int i = 0; i < 4; i++)
                if (i <= int'(mem_dlen)) mem[mem_addr + 12'(i)] <= mem_data[8*i +: 8];
        end
    end

    always_comb begin
        mem_q = '0;
        for (int i = 0; i < 4; i++) mem_q[8*i +: 8] = mem[mem_addr + 12'(i)];
    end

    // one full request/response exchange starting from IDLE, #1 after an edge
    task automatic txn(input logic we, input logic [1:0] dl, input logic sg,
                       input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic f, output int lat);
        cpu.req_valid = 1'b1; cpu.req_we = we; cpu.req_dlen = dl;
        cpu.req_signed = sg; cpu.req_addr = a; cpu.req_wdata = wd;
        lat = 0;
        @(posedge clk); #1;
        cpu.req_valid = 1'b0;
        while (!cpu.resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = cpu.resp_rdata;
        f = cpu.resp_fault;
        cpu.resp_ready = 1'b1;
        @(posedge clk); #1;
        cpu.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cpu.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", cpu.req_ready); end
        checks++; if (cpu.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", cpu.resp_valid); end
        checks++; if (cpu.resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", cpu.resp_rdata); end
        checks++; if (cpu.resp_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", cpu.resp_fault); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if ({mem_addr, mem_dlen, mem_data} !== 46'h0) begin failures++; $display("FAIL reset_mem_bus got=%h/%h/%h exp=0", mem_addr, mem_dlen, mem_data); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic f; int lat;
        txn(1'b1, 2'd3, 1'b0, 12'h010, 32'h89ABCDEF, rd, f, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL store_latency got=%0d exp=1", lat); end
        checks++; if ({f, rd} !== 33'h0) begin failures++; $display("FAIL store_resp got=%b/%h exp=0/0", f, rd); end
        txn(1'b0, 2'd0, 1'b1, 12'h010, 32'h0, rd, f, lat);
        checks++; if ({f, rd} !== {1'b0, 32'hFFFFFFEF}) begin failures++; $display("FAIL load_b_signed got=%b/%h exp=0/ffffffef", f, rd); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL load_latency got=%0d exp=1", lat); end
        txn(1'b0, 2'd1, 1'b0, 12'h012, 32'h0, rd, f, lat);
        checks++; if ({f, rd} !== {1'b0, 32'h000089AB}) begin failures++; $display("FAIL load_h_unsigned got=%b/%h exp=0/000089ab", f, rd); end
        txn(1'b0, 2'd1, 1'b1, 12'h012, 32'h0, rd, f, lat);
        checks++; if ({f, rd} !== {1'b0, 32'hFFFF89AB}) begin failures++; $display("FAIL load_h_signed got=%b/%h exp=0/ffff89ab", f, rd); end
        txn(1'b0, 2'd2, 1'b1, 12'h010, 32'h0, rd, f, lat);
        checks++; if ({f, rd} !== {1'b0, 32'hFFABCDEF}) begin failures++; $display("FAIL load_3b_signed got=%b/%h exp=0/ffabcdef", f, rd); end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic f; int lat; int w;
        txn(1'b1, 2'd3, 1'b0, 12'hFFC, 32'h11223344, rd, f, lat);
        checks++; if (f !== 1'b0) begin failures++; $display("FAIL top_store_fault got=%b exp=0", f); end
        w = we_cnt;
        txn(1'b1, 2'd3, 1'b0, 12'hFFE, 32'hDEADBEEF, rd, f, lat);
        checks++; if ({f, rd} !== {1'b1, 32'h0}) begin failures++; $display("FAIL cross_store_resp got=%b/%h exp=1/0", f, rd); end
        checks++; if (we_cnt !== w) begin failures++; $display("FAIL cross_store_we got=%0d exp=%0d", we_cnt, w); end
        txn(1'b0, 2'd3, 1'b0, 12'hFFC, 32'h0, rd, f, lat);
        checks++; if ({f, rd} !== {1'b0, 32'h11223344}) begin failures++; $display("FAIL top_bytes_kept got=%b/%h exp=0/11223344", f, rd); end
        txn(1'b0, 2'd1, 1'b1, 12'hFFF, 32'h0, rd, f, lat);
        checks++; if ({f, rd} !== {1'b1, 32'h0}) begin failures++; $display("FAIL cross_load_resp got=%b/%h exp=1/0", f, rd); end
        txn(1'b0, 2'd0, 1'b1, 12'hFFF, 32'h0, rd, f, lat);
        checks++; if ({f, rd} !== {1'b0, 32'h00000011}) begin failures++; $display("FAIL top_byte_load got=%b/%h exp=0/00000011", f, rd); end
    endtask

    task automatic test_stall();
        int w;
        cpu.req_valid = 1'b1; cpu.req_we = 1'b0; cpu.req_dlen = 2'd3;
        cpu.req_signed = 1'b0; cpu.req_addr = 12'h010;
        @(posedge clk); #1;
        cpu.req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if ({cpu.resp_valid, cpu.resp_rdata} !== {1'b1, 32'h89ABCDEF}) begin failures++; $display("FAIL stall_first_resp got=%b/%h exp=1/89abcdef", cpu.resp_valid, cpu.resp_rdata); end
        w = we_cnt;
        cpu.req_valid = 1'b1; cpu.req_we = 1'b1; cpu.req_addr = 12'h030; cpu.req_wdata = 32'h55555555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if ({cpu.resp_valid, cpu.req_ready, cpu.resp_fault, cpu.resp_rdata} !== {3'b100, 32'h89ABCDEF}) begin failures++; $display("FAIL stall_hold_%0d got=%b%b%b/%h exp=100/89abcdef", i, cpu.resp_valid, cpu.req_ready, cpu.resp_fault, cpu.resp_rdata); end
        end
        cpu.req_valid = 1'b0;
        cpu.resp_ready = 1'b1;
        @(posedge clk); #1;
        cpu.resp_ready = 1'b0;
        checks++; if ({cpu.resp_valid, cpu.req_ready} !== 2'b01) begin failures++; $display("FAIL stall_release got=%b%b exp=01", cpu.resp_valid, cpu.req_ready); end
        @(posedge clk); #1;
        checks++; if (we_cnt !== w) begin failures++; $display("FAIL stall_no_accept got=%0d exp=%0d", we_cnt, w); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; logic f; int lat;
        txn(1'b1, 2'd3, 1'b0, 12'h020, 32'hCAFEF00D, rd, f, lat);
        txn(1'b0, 2'd3, 1'b0, 12'h020, 32'h0, rd, f, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL rst_pre_load got=%h exp=cafef00d", rd); end
        cpu.req_valid = 1'b1; cpu.req_we = 1'b1; cpu.req_dlen = 2'd3;
        cpu.req_addr = 12'h020; cpu.req_wdata = 32'h12345678;
        @(posedge clk); #1;
        cpu.req_valid = 1'b0;
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rst_access_we got=%b exp=1", mem_we); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mid_we got=%b exp=0", mem_we); end
        checks++; if ({cpu.req_ready, cpu.resp_valid, cpu.resp_fault, cpu.resp_rdata} !== {3'b100, 32'h0}) begin failures++; $display("FAIL rst_mid_cpu got=%b%b%b/%h exp=100/0", cpu.req_ready, cpu.resp_valid, cpu.resp_fault, cpu.resp_rdata); end
        checks++; if ({mem_addr, mem_dlen, mem_data} !== 46'h0) begin failures++; $display("FAIL rst_mid_mem_bus got=%h/%h/%h exp=0", mem_addr, mem_dlen, mem_data); end
        cpu.req_valid = 1'b1; cpu.req_we = 1'b0; cpu.req_dlen = 2'd3; cpu.req_signed = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (cpu.req_ready !== 1'b1) begin failures++; $display("FAIL rst_held_idle got=%b exp=1", cpu.req_ready); end
        @(posedge clk); #1;
        checks++; if (cpu.req_ready !== 1'b0) begin failures++; $display("FAIL rst_release_accept got=%b exp=0", cpu.req_ready); end
        cpu.req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if ({cpu.resp_valid, cpu.resp_rdata} !== {1'b1, 32'hCAFEF00D}) begin failures++; $display("FAIL rst_bytes_kept got=%b/%h exp=1/cafef00d", cpu.resp_valid, cpu.resp_rdata); end
        cpu.resp_ready = 1'b1;
        @(posedge clk); #1;
        cpu.resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [11:0] ad [3] = '{12'h010, 12'h011, 12'h012};
        logic [1:0]  dl [3] = '{2'd0, 2'd0, 2'd1};
        logic        sg [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] ex [3] = '{32'h000000EF, 32'hFFFFFFCD, 32'h000089AB};
        int prev = 0;
        cpu.resp_ready = 1'b1;
        cpu.req_valid = 1'b1;
        cpu.req_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cpu.req_addr = ad[k]; cpu.req_dlen = dl[k]; cpu.req_signed = sg[k];
            @(posedge clk); #1;
            checks++; if (cpu.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept_%0d got=%b exp=0", k, cpu.req_ready); end
            if (k > 0) begin
                checks++; if (cyc - prev !== 3) begin failures++; $display("FAIL b2b_spacing_%0d got=%0d exp=3", k, cyc - prev); end
            end
            prev = cyc;
            @(posedge clk); #1;
            checks++; if ({cpu.resp_valid, cpu.req_ready, cpu.resp_rdata} !== {2'b10, ex[k]}) begin failures++; $display("FAIL b2b_resp_%0d got=%b%b/%h exp=10/%h", k, cpu.resp_valid, cpu.req_ready, cpu.resp_rdata, ex[k]); end
            @(posedge clk); #1;
            checks++; if ({cpu.resp_valid, cpu.req_ready} !== 2'b01) begin failures++; $display("FAIL b2b_idle_%0d got=%b%b exp=01", k, cpu.resp_valid, cpu.req_ready); end
        end
        cpu.req_valid = 1'b0;
        cpu.resp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cpu.req_valid = 1'b0; cpu.req_we = 1'b0; cpu.req_dlen = 2'd0; cpu.req_signed = 1'b0;
        cpu.req_addr = '0; cpu.req_wdata = '0; cpu.resp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_fault();
        test_stall();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
